// File: rtl/fifo_n2one_wr_arbiter_pkg.sv
// Shared definitions for the many-to-one FIFO write-side arbiter.
// Holds the FSM state encoding and a helper for the packing ratio.
package fifo_n2one_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Number of narrow units packed into one FIFO output word
  function automatic int units_per_word(input int o_width, input int i_width);
    return o_width / i_width;
  endfunction

endpackage

// File: rtl/fifo_n2one_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester after last_grant
// (wrapping) with its request bit set wins.
module fifo_n2one_wr_arbiter_rr_picker
  import fifo_n2one_wr_arbiter_pkg::*;
#(
  parameter int P_NUM_REQ = 4
) (
  input  logic [P_NUM_REQ-1:0]         req,
  input  logic [$clog2(P_NUM_REQ)-1:0] last_grant,
  output logic [$clog2(P_NUM_REQ)-1:0] winner,
  output logic                         any_req
);

  localparam int L_ID_W = $clog2(P_NUM_REQ);

  logic [L_ID_W-1:0] idx_s;

  // Scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    winner = '0;
    idx_s  = '0;
    for (int i = P_NUM_REQ; i >= 1; i--) begin
      idx_s = L_ID_W'((int'(last_grant) + i) % P_NUM_REQ);
      if (req[idx_s]) begin
        winner = idx_s;
      end else begin
        winner = winner;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_n2one_wr_arbiter.sv
// Write-side arbiter for the many-to-one FIFO: locks one requester per wide
// output word and hands the narrow write port around in round-robin order.
module fifo_n2one_wr_arbiter
  import fifo_n2one_wr_arbiter_pkg::*;
#(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_I_MSB = 7,
  parameter int P_DATA_O_MSB = 31
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [P_NUM_REQ-1:0]                   i_valid,
  input  logic [P_NUM_REQ*(P_DATA_I_MSB+1)-1:0]  i_data,
  output logic [P_NUM_REQ-1:0]                   o_ready,
  output logic                                   o_fifo_inc,
  output logic [P_DATA_I_MSB:0]                  o_fifo_data,
  input  logic                                   i_fifo_full,
  output logic                                   o_busy,
  output logic [$clog2(P_NUM_REQ)-1:0]           o_grant_id
);

  localparam int L_W       = P_DATA_I_MSB + 1;
  localparam int L_UNITS   = units_per_word(P_DATA_O_MSB + 1, L_W);
  localparam int L_ID_MSB  = $clog2(P_NUM_REQ) - 1;
  localparam int L_ID_W    = L_ID_MSB + 1;
  localparam int L_CNT_W   = $clog2(L_UNITS + 1);

  state_e              state_r;
  logic [L_CNT_W-1:0]  count_r;
  logic [L_ID_MSB:0]   grant_r;
  logic [L_ID_MSB:0]   last_grant_r;

  logic [P_NUM_REQ-1:0] ready_s;
  logic                 transfer_s;
  logic                 last_unit_s;
  logic [L_ID_MSB:0]    pick_base_s;
  logic [L_ID_MSB:0]    winner_s;
  logic                 any_req_s;

  // In LOCK the next word is arbitrated from the current grant, so the
  // current requester only re-wins when nobody else is asking.
  assign pick_base_s = (state_r == ST_LOCK) ? grant_r : last_grant_r;

  fifo_n2one_wr_arbiter_rr_picker #(
    .P_NUM_REQ (P_NUM_REQ)
  ) u_rr_picker (
    .req        (i_valid),
    .last_grant (pick_base_s),
    .winner     (winner_s),
    .any_req    (any_req_s)
  );

  // Only the locked requester may transfer, and only while the FIFO has room
  always_comb begin
    ready_s    = '0;
    transfer_s = 1'b0;
    if (state_r == ST_LOCK && !i_fifo_full) begin
      ready_s[grant_r] = 1'b1;
      transfer_s       = i_valid[grant_r];
    end else begin
      ready_s    = '0;
      transfer_s = 1'b0;
    end
  end

  assign last_unit_s = transfer_s && (count_r == L_CNT_W'(L_UNITS - 1));

  assign o_ready     = ready_s;
  assign o_fifo_inc  = transfer_s;
  assign o_fifo_data = i_data[grant_r*L_W +: L_W];
  assign o_busy      = (state_r == ST_LOCK);
  assign o_grant_id  = grant_r;

  // Lock/count FSM; a word is never abandoned except by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      count_r      <= '0;
      grant_r      <= '0;
      last_grant_r <= L_ID_W'(P_NUM_REQ - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= winner_s;
            count_r <= '0;
            state_r <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (last_unit_s) begin
            last_grant_r <= grant_r;
            count_r      <= '0;
            if (any_req_s) begin
              grant_r <= winner_s;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (transfer_s) begin
            count_r <= count_r + L_CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_n2one_wr_arbiter.sv
// Randomised scoreboard bench for fifo_n2one_wr_arbiter, plus a second
// instance with one unit per word.
module tb_fifo_n2one_wr_arbiter;

  localparam int N = 4;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst1_n = 1'b0;
  logic [3:0]  valid = '0;
  logic [31:0] data = '0;
  logic [3:0]  ready;
  logic        inc;
  logic [7:0]  fdata;
  logic        full = 1'b0;
  logic        busy;
  logic [1:0]  gid;

  logic [3:0]   valid1 = '0;
  logic [127:0] data1 = {32'h0, 32'h0, 32'hBBBB_0001, 32'hAAAA_0000};
  logic [3:0]   ready1;
  logic         inc1;
  logic [31:0]  fdata1;
  logic         busy1;
  logic [1:0]   gid1;

  always #5 clk = ~clk;

  fifo_n2one_wr_arbiter #(.P_NUM_REQ(4), .P_DATA_I_MSB(7), .P_DATA_O_MSB(31)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data), .o_ready(ready),
    .o_fifo_inc(inc), .o_fifo_data(fdata), .i_fifo_full(full), .o_busy(busy),
    .o_grant_id(gid)
  );

  fifo_n2one_wr_arbiter #(.P_NUM_REQ(4), .P_DATA_I_MSB(31), .P_DATA_O_MSB(31)) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_valid(valid1), .i_data(data1), .o_ready(ready1),
    .o_fifo_inc(inc1), .o_fifo_data(fdata1), .i_fifo_full(1'b0), .o_busy(busy1),
    .o_grant_id(gid1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Scoreboard: units each requester has presented, in order
  logic [7:0] exp_q [4][$];
  logic [7:0] next_val [4];
  int         issued [4];

  // Reference model at word level: owner, units done in its word, last owner
  bit mon_en = 1'b0;
  bit busy_m = 1'b0;
  int owner_m = 0;
  int last_m = N - 1;
  int done_m = 0;
  int inc_total = 0;
  int inc_first = -1;
  int inc_last = -1;

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic [3:0] exp_ready;
      logic       exp_inc;
      exp_ready = (busy_m && !full) ? (4'b0001 << owner_m) : 4'b0000;
      exp_inc   = busy_m && !full && valid[owner_m];
      check("ready", {28'h0, ready}, {28'h0, exp_ready});
      check("busy", {31'h0, busy}, {31'h0, busy_m});
      check("inc", {31'h0, inc}, {31'h0, exp_inc});
      if (busy_m) check("grant_id", {30'h0, gid}, owner_m);
      if (inc) begin
        if (exp_q[owner_m].size() == 0) begin
          n_checks++;
          $display("FAIL data: got %0h with no unit pending for requester %0d", fdata, owner_m);
        end else begin
          check("data", {24'h0, fdata}, {24'h0, exp_q[owner_m].pop_front()});
        end
        inc_total++;
        if (inc_first < 0) inc_first = cyc;
        inc_last = cyc;
      end
      if (!busy_m) begin
        if (|valid) begin
          owner_m = rr_pick(last_m, valid);
          busy_m  = 1'b1;
          done_m  = 0;
        end
      end else if (exp_inc) begin
        done_m++;
        if (done_m == L) begin
          last_m = owner_m;
          done_m = 0;
          if (|valid) owner_m = rr_pick(owner_m, valid);
          else busy_m = 1'b0;
        end
      end
    end
  end

  // Single-unit-word instance: requesters 0 and 1 must alternate
  int m2_cnt = 0;
  int m2_exp = 0;
  always @(negedge clk) begin
    if (rst1_n && m2_cnt < 16 && inc1) begin
      check("l1_grant", {30'h0, gid1}, m2_exp);
      check("l1_data", fdata1, (m2_exp == 0) ? 32'hAAAA_0000 : 32'hBBBB_0001);
      m2_exp = 1 - m2_exp;
      m2_cnt++;
    end
  end

  task automatic present(input int k);
    data[k*8 +: 8] = next_val[k];
    exp_q[k].push_back(next_val[k]);
    next_val[k] = next_val[k] + 8'd1;
    issued[k]++;
    valid[k] = 1'b1;
  endtask

  // One bus cycle of requester behaviour; rnd adds gaps and FIFO-full stalls
  task automatic step(input logic [3:0] en, input bit rnd);
    logic [3:0] acc;
    @(negedge clk);
    acc = valid & ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (valid[k] && acc[k]) begin
        if (en[k] && (!rnd || $urandom_range(0, 3) != 0)) present(k);
        else valid[k] = 1'b0;
      end else if (!valid[k] && en[k] && (!rnd || $urandom_range(0, 2) == 0)) begin
        present(k);
      end
    end
    full = rnd ? ($urandom_range(0, 99) < 20) : 1'b0;
  endtask

  task automatic reset_model();
    busy_m = 1'b0;
    owner_m = 0;
    last_m = N - 1;
    done_m = 0;
    for (int k = 0; k < N; k++) exp_q[k].delete();
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < N; k++) begin
      next_val[k] = 8'(k * 64);
      issued[k] = 0;
    end
    next_val[0] = 8'h10;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", {28'h0, ready}, 32'h0);
    check("rst_inc", {31'h0, inc}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_grant", {30'h0, gid}, 32'h0);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    valid1 = 4'b0011;
    mon_en = 1'b1;

    // Single requester streams two words 0x10..0x17
    for (int t = 0; t < 30; t++) step((issued[0] < 8) ? 4'b0001 : 4'b0000, 1'b0);
    check("stream_count", inc_total, 8);
    check("stream_span", inc_last - inc_first, 7);

    // Random contention with gaps and FIFO-full stalls
    for (int t = 0; t < 3000; t++) step(4'b1111, 1'b1);

    // Reset in the middle of a word (two units already written)
    seen = 1'b0;
    for (int t = 0; t < 2000 && !(busy_m && done_m == 2); t++) step(4'b1111, 1'b1);
    if (!(busy_m && done_m == 2)) begin
      n_checks++;
      $display("FAIL rst_wait: no mid-word point reached within the cycle budget");
    end
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {28'h0, ready}, 32'h0);
    check("midrst_inc", {31'h0, inc}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    valid = '0;
    full = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // After release the lowest valid index (from 0) wins first
    for (int t = 0; t < 40; t++) begin
      step(4'b1100, 1'b0);
      if (busy && !seen) begin
        check("rst_first_grant", {30'h0, gid}, 32'd2);
        seen = 1'b1;
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL rst_first_grant: no grant within the cycle budget");
    end
    for (int t = 0; t < 10; t++) step(4'b0000, 1'b0);
    check("l1_word_count", m2_cnt, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
